// File: rtl/seq_mul.sv
// Iterative shift-and-add multiplier, full 2*WIDTH product, start/done handshake.
// Signed only when both operands are flagged signed (Verilog expression-sign rule).
module seq_mul #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 a_signed,
  input  logic                 b_signed,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p,
  output logic [1:0]           dbg_state
);

  // Handshake: start is sampled on a rising edge only while busy=0; done is a
  // one-cycle pulse on which p is new, and p holds until the next done.

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]        LAST  = CW'(WIDTH - 1);
  localparam logic [CW-1:0]        ONE_C = CW'(1);
  localparam logic [WIDTH-1:0]     ONE_W = WIDTH'(1);
  localparam logic [2*WIDTH-1:0]   ONE_P = (2*WIDTH)'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t               state, state_nx;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic                 neg;
  logic [2*WIDTH-1:0]   acc;
  logic [CW-1:0]        count;
  logic                 smode;
  logic [2*WIDTH-1:0]   ext_a;

  assign smode     = a_signed & b_signed;
  assign ext_a     = {{WIDTH{1'b0}}, mag_a};
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (count == LAST) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag_a <= '0;
      mag_b <= '0;
      neg   <= 1'b0;
      acc   <= '0;
      count <= '0;
      p     <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Magnitudes are unsigned WIDTH-bit; -2^(W-1) maps to 2^(W-1).
            mag_a <= (smode && a[WIDTH-1]) ? (~a + ONE_W) : a;
            mag_b <= (smode && b[WIDTH-1]) ? (~b + ONE_W) : b;
            neg   <= smode & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc   <= '0;
            count <= '0;
          end
        end
        RUN: begin
          if (mag_b[0]) acc <= acc + (ext_a << count);
          mag_b <= mag_b >> 1;
          count <= count + ONE_C;
        end
        FIN: begin
          p    <= neg ? (~acc + ONE_P) : acc;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul.sv
// Self-checking bench for seq_mul at WIDTH=5: directed corner cases, handshake
// timing, reset abort, and an all-pairs sweep in every sign-flag combination.
module tb_seq_mul;

  localparam int W = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   a, b;
  logic           a_signed, b_signed;
  logic           busy, done;
  logic [2*W-1:0] p;
  logic [1:0]     dbg_state;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  logic [2*W-1:0] exp_q[$];

  seq_mul #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .a_signed(a_signed), .b_signed(b_signed),
    .busy(busy), .done(done), .p(p), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: integer product under the Verilog sign rule, kept to 2W bits.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic xs, input logic ys);
    longint vx, vy, pr;
    vx = longint'(x);
    vy = longint'(y);
    if (xs && ys) begin
      if (x[W-1]) vx = vx - (longint'(1) << W);
      if (y[W-1]) vy = vy - (longint'(1) << W);
    end
    pr = vx * vy;
    return pr[2*W-1:0];
  endfunction

  // Scoreboard: predict on every accepted start, retire on every done.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        done_cnt++;
        check("done_has_expectation", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("p", 32'(p), 32'(exp_q.pop_front()));
      end
      if (start && !busy) exp_q.push_back(model(a, b, a_signed, b_signed));
    end
  end

  task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic xs, input logic ys);
    a = x; b = y; a_signed = xs; b_signed = ys;
  endtask

  // One isolated multiply; checks latency, busy span and a single done.
  task automatic run_one(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic xs, input logic ys, input logic timing);
    int busy_cyc, done_at, d0;
    busy_cyc = 0; done_at = -1; d0 = done_cnt;
    @(negedge clk);
    drive(x, y, xs, ys);
    start = 1'b1;
    for (int i = 1; i <= W + 3; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (busy) busy_cyc++;
      if (done && done_at < 0) done_at = i;
    end
    if (timing) begin
      check("done_latency", 32'(done_at), 32'(W + 2));
      check("busy_cycles", 32'(busy_cyc), 32'(W + 1));
    end
    check("one_done", 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int marks[4];
    int nm, d0, off;
    logic [9:0] idx;
    rst = 1'b1; start = 1'b0;
    drive('0, '0, 1'b0, 1'b0);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_p", 32'(p), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed corner cases.
    run_one(5'b11111, 5'b00011, 1'b1, 1'b1, 1'b1);
    check("neg1_times_3", 32'(p), 32'h3FD);
    run_one(5'b11111, 5'b00011, 1'b0, 1'b1, 1'b1);
    check("mixed_unsigned", 32'(p), 32'h05D);
    run_one(5'b10000, 5'b10000, 1'b1, 1'b1, 1'b1);
    check("minneg_squared", 32'(p), 32'h100);
    run_one(5'b10000, 5'b10000, 1'b0, 1'b0, 1'b0);
    check("u16_squared", 32'(p), 32'h100);
    run_one(5'b10000, 5'b00001, 1'b1, 1'b1, 1'b0);
    check("minneg_times_1", 32'(p), 32'h3F0);
    run_one(5'b11111, 5'b00000, 1'b1, 1'b1, 1'b0);
    check("neg1_times_0", 32'(p), 32'h000);
    run_one(5'b00000, 5'b10000, 1'b1, 1'b1, 1'b0);
    check("0_times_minneg", 32'(p), 32'h000);

    // A second start while busy must be ignored.
    run_one(5'b01011, 5'b00111, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    d0 = done_cnt;
    drive(5'b00110, 5'b01101, 1'b1, 1'b1);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    drive(5'b11011, 5'b10101, 1'b0, 1'b0);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (W + 2) @(negedge clk);
    check("ignored_start_one_done", 32'(done_cnt - d0), 32'd1);
    check("ignored_start_p", 32'(p), 32'(model(5'b00110, 5'b01101, 1'b1, 1'b1)));

    // start held high: next accept lands in the done cycle.
    @(negedge clk);
    drive(5'b10011, 5'b01110, 1'b1, 1'b1);
    start = 1'b1;
    nm = 0;
    for (int i = 0; i < 80 && nm < 4; i++) begin
      @(negedge clk);
      if (done) begin marks[nm] = i; nm++; end
    end
    start = 1'b0;
    check("held_done_count", 32'(nm), 32'd4);
    for (int k = 1; k < 4; k++) check("held_done_spacing", 32'(marks[k] - marks[k-1]), 32'(W + 2));
    repeat (W + 3) @(negedge clk);
    check("held_queue_drained", 32'(exp_q.size()), 32'd0);

    // Reset abort after two RUN edges.
    run_one(5'b01111, 5'b01111, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    d0 = done_cnt;
    drive(5'b01001, 5'b00101, 1'b0, 1'b0);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_p", 32'(p), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (W + 4) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    run_one(5'b10110, 5'b01001, 1'b1, 1'b1, 1'b1);
    check("after_abort_p", 32'(p), 32'(model(5'b10110, 5'b01001, 1'b1, 1'b1)));

    // All operand pairs per sign combination, in randomly rotated order.
    for (int m = 0; m < 4; m++) begin
      off = int'($urandom_range(0, 1023));
      for (int i = 0; i < 1024; i++) begin
        idx = 10'(i + off);
        run_one(idx[9:5], idx[4:0], m[1], m[0], 1'b0);
      end
    end

    // Random back-to-back with random flags.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      drive(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      start = 1'($urandom_range(0, 1));
    end
    start = 1'b0;
    repeat (W + 4) @(negedge clk);
    check("final_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
